// File: rtl/dm_pkg.sv
// Debug-module DMI types shared with the RISC-V debug module.
package dm;

  // DMI operation encoding
  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  // DMI request: {addr, op, data}
  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  // DMI response: {data, resp}
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/safety_island_pkg.sv
// Constants and types for the Safety Island DMI preload engine.
package safety_island_pkg;

  // Debug-module register addresses used for System Bus Access
  localparam logic [6:0] DMI_SBCS       = 7'h38;
  localparam logic [6:0] DMI_SBADDRESS0 = 7'h39;
  localparam logic [6:0] DMI_SBDATA0    = 7'h3C;

  // sbcs: 32-bit access, autoincrement, clear sbbusyerror and sberror
  localparam logic [31:0] SBCS_CFG = 32'h0045_7000;

  // sbcs field positions inspected while polling
  localparam int unsigned SBCS_SBBUSYERROR_BIT = 22;
  localparam int unsigned SBCS_SBBUSY_BIT      = 21;
  localparam int unsigned SBCS_SBERROR_MSB     = 14;
  localparam int unsigned SBCS_SBERROR_LSB     = 12;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_DMI_RESP     = 3'd1,
    ERR_SBERROR      = 3'd2,
    ERR_SBBUSYERROR  = 3'd3,
    ERR_POLL_TIMEOUT = 3'd4
  } err_code_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_REQ,
    ST_CFG_RSP,
    ST_ADDR_REQ,
    ST_ADDR_RSP,
    ST_DATA_WAIT,
    ST_DATA_REQ,
    ST_DATA_RSP,
    ST_POLL_REQ,
    ST_POLL_RSP,
    ST_FIN
  } loader_state_e;

  // States in which a DMI request is being offered
  function automatic logic is_req_state(input loader_state_e s);
    return (s == ST_CFG_REQ) || (s == ST_ADDR_REQ) ||
           (s == ST_DATA_REQ) || (s == ST_POLL_REQ);
  endfunction

  // States in which a DMI response is being awaited
  function automatic logic is_rsp_state(input loader_state_e s);
    return (s == ST_CFG_RSP) || (s == ST_ADDR_RSP) ||
           (s == ST_DATA_RSP) || (s == ST_POLL_RSP);
  endfunction

endpackage

// File: rtl/safety_island_dmi_loader.sv
// Preload engine: streams 32-bit words into memory via DMI System Bus Access.
module safety_island_dmi_loader
  import safety_island_pkg::*;
#(
  parameter int unsigned MaxPoll = 1024
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [31:0]    base_addr_i,
  input  logic           data_valid_i,
  output logic           data_ready_o,
  input  logic [31:0]    data_i,
  input  logic           data_last_i,
  output logic           dmi_req_valid_o,
  input  logic           dmi_req_ready_i,
  output dm::dmi_req_t   dmi_req_o,
  input  logic           dmi_resp_valid_i,
  output logic           dmi_resp_ready_o,
  input  dm::dmi_resp_t  dmi_resp_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           error_o,
  output logic [2:0]     err_code_o,
  output logic [31:0]    words_o
);

  loader_state_e state_q, state_d;
  err_code_e     err_q, fin_code;
  logic [31:0]   base_q;
  logic [31:0]   words_q;
  logic [31:0]   poll_cnt_q;
  logic          last_q;
  logic          req_valid_q;
  dm::dmi_req_t  req_q, req_d;

  logic start_fire, data_fire, resp_fire, resp_err, sb_busy, sb_busyerror, sb_error;
  logic unused_resp_bits;

  assign start_fire   = (state_q == ST_IDLE) && start_i;
  assign data_fire    = (state_q == ST_DATA_WAIT) && data_valid_i;
  assign resp_fire    = dmi_resp_ready_o && dmi_resp_valid_i;
  assign resp_err     = (dmi_resp_i.resp != 2'd0);
  assign sb_busy      = dmi_resp_i.data[SBCS_SBBUSY_BIT];
  assign sb_busyerror = dmi_resp_i.data[SBCS_SBBUSYERROR_BIT];
  assign sb_error     = (dmi_resp_i.data[SBCS_SBERROR_MSB:SBCS_SBERROR_LSB] != 3'd0);

  // sbcs bits that the poll does not inspect
  assign unused_resp_bits = ^{dmi_resp_i.data[31:23], dmi_resp_i.data[20:15],
                              dmi_resp_i.data[11:0]};

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    // NOTE: every register is reset here, datapath included, because all of
    // them are visible on outputs and must read 0 straight out of reset.
    if (rst_i) begin
      state_q     <= ST_IDLE;
      err_q       <= ERR_NONE;
      base_q      <= '0;
      words_q     <= '0;
      poll_cnt_q  <= '0;
      last_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      req_valid_q <= is_req_state(state_d);
      req_q       <= req_d;
      if (start_fire) begin
        base_q     <= base_addr_i;
        words_q    <= '0;
        poll_cnt_q <= '0;
        err_q      <= ERR_NONE;
      end
      if (data_fire) begin
        last_q <= data_last_i;
      end
      if ((state_q == ST_DATA_RSP) && resp_fire && !resp_err) begin
        words_q <= words_q + 32'd1;
      end
      if ((state_q == ST_POLL_RSP) && resp_fire) begin
        poll_cnt_q <= poll_cnt_q + 32'd1;
      end
      if ((state_d == ST_FIN) && (state_q != ST_FIN)) begin
        err_q <= fin_code;
      end
    end
  end

  // Next-state logic and the completion code committed on entry to FIN
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    fin_code = ERR_NONE;
    case (state_q)
      ST_IDLE:      if (start_i)         state_d = ST_CFG_REQ;
      ST_CFG_REQ:   if (dmi_req_ready_i) state_d = ST_CFG_RSP;
      ST_CFG_RSP: begin
        if (resp_fire) begin
          if (resp_err) begin
            state_d  = ST_FIN;
            fin_code = ERR_DMI_RESP;
          end else begin
            state_d = ST_ADDR_REQ;
          end
        end
      end
      ST_ADDR_REQ:  if (dmi_req_ready_i) state_d = ST_ADDR_RSP;
      ST_ADDR_RSP: begin
        if (resp_fire) begin
          if (resp_err) begin
            state_d  = ST_FIN;
            fin_code = ERR_DMI_RESP;
          end else begin
            state_d = ST_DATA_WAIT;
          end
        end
      end
      ST_DATA_WAIT: if (data_valid_i)    state_d = ST_DATA_REQ;
      ST_DATA_REQ:  if (dmi_req_ready_i) state_d = ST_DATA_RSP;
      ST_DATA_RSP: begin
        if (resp_fire) begin
          if (resp_err) begin
            state_d  = ST_FIN;
            fin_code = ERR_DMI_RESP;
          end else if (last_q) begin
            state_d = ST_POLL_REQ;
          end else begin
            state_d = ST_DATA_WAIT;
          end
        end
      end
      ST_POLL_REQ:  if (dmi_req_ready_i) state_d = ST_POLL_RSP;
      ST_POLL_RSP: begin
        if (resp_fire) begin
          state_d = ST_FIN;
          if (resp_err) begin
            fin_code = ERR_DMI_RESP;
          end else if (sb_busyerror) begin
            fin_code = ERR_SBBUSYERROR;
          end else if (sb_error) begin
            fin_code = ERR_SBERROR;
          end else if (sb_busy) begin
            // This read is number poll_cnt_q + 1
            if ((poll_cnt_q + 32'd1) >= 32'(MaxPoll)) begin
              fin_code = ERR_POLL_TIMEOUT;
            end else begin
              state_d = ST_POLL_REQ;
            end
          end
        end
      end
      ST_FIN:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // DMI request payload for the state being entered; held while it waits for ready
  always_comb begin
    req_d = '0;
    case (state_d)
      ST_CFG_REQ: begin
        req_d.addr = DMI_SBCS;
        req_d.op   = dm::DTM_WRITE;
        req_d.data = SBCS_CFG;
      end
      ST_ADDR_REQ: begin
        req_d.addr = DMI_SBADDRESS0;
        req_d.op   = dm::DTM_WRITE;
        req_d.data = base_q;
      end
      ST_DATA_REQ: begin
        req_d.addr = DMI_SBDATA0;
        req_d.op   = dm::DTM_WRITE;
        req_d.data = (state_q == ST_DATA_WAIT) ? data_i : req_q.data;
      end
      ST_POLL_REQ: begin
        req_d.addr = DMI_SBCS;
        req_d.op   = dm::DTM_READ;
        req_d.data = '0;
      end
      default: req_d = '0;
    endcase
  end

  // Outputs decoded from the current state and registers
  always_comb begin
    data_ready_o     = (state_q == ST_DATA_WAIT);
    dmi_resp_ready_o = is_rsp_state(state_q);
    busy_o           = (state_q != ST_IDLE) && (state_q != ST_FIN);
    done_o           = (state_q == ST_FIN);
    error_o          = (err_q != ERR_NONE);
    err_code_o       = err_q;
    words_o          = words_q;
    dmi_req_valid_o  = req_valid_q;
    dmi_req_o        = req_q;
  end

endmodule

// File: tb/tb_safety_island_dmi_loader.sv
// Self-checking bench for safety_island_dmi_loader with a behavioural DMI slave.
module tb_safety_island_dmi_loader;

  localparam int MAX_POLL = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [31:0]   base_addr_i = '0;
  logic          data_valid_i = 1'b0;
  logic          data_ready_o;
  logic [31:0]   data_i = '0;
  logic          data_last_i = 1'b0;
  logic          dmi_req_valid_o;
  logic          dmi_req_ready_i = 1'b0;
  dm::dmi_req_t  dmi_req_o;
  logic          dmi_resp_valid_i = 1'b0;
  logic          dmi_resp_ready_o;
  dm::dmi_resp_t dmi_resp_i = '0;
  logic          busy_o, done_o, error_o;
  logic [2:0]    err_code_o;
  logic [31:0]   words_o;

  always #5 clk = ~clk;

  safety_island_dmi_loader #(.MaxPoll(MAX_POLL)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .base_addr_i     (base_addr_i),
    .data_valid_i    (data_valid_i),
    .data_ready_o    (data_ready_o),
    .data_i          (data_i),
    .data_last_i     (data_last_i),
    .dmi_req_valid_o (dmi_req_valid_o),
    .dmi_req_ready_i (dmi_req_ready_i),
    .dmi_req_o       (dmi_req_o),
    .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o),
    .dmi_resp_i      (dmi_resp_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .err_code_o      (err_code_o),
    .words_o         (words_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scenario knobs, written only by the main initial block
  bit          slave_en = 1'b0, stream_en = 1'b0, idle_offer = 1'b0;
  int          cfg_stall = 0, cfg_err_at = 0, cfg_busy = 0;
  logic [2:0]  cfg_sberr = '0;
  bit          cfg_sbbe = 1'b0, cfg_gappy = 1'b0;
  logic [31:0] stream_words[$];

  // DMI slave state
  dm::dmi_req_t  obs_reqs[$];
  dm::dmi_req_t  held_req;
  dm::dmi_resp_t pend_resp;
  bit            pending = 1'b0;
  int            stall_cnt = 0, req_cnt = 0, poll_seen = 0;
  int            unstable_cnt = 0, resp_unready_cnt = 0, done_cnt = 0;

  // DMI slave: accepts requests after cfg_stall cycles, answers one cycle later
  always @(negedge clk) begin
    if (rst_i || !slave_en) begin
      dmi_req_ready_i  = 1'b0;
      dmi_resp_valid_i = 1'b0;
      dmi_resp_i       = '0;
      pending          = 1'b0;
      stall_cnt        = 0;
      req_cnt          = 0;
      poll_seen        = 0;
      unstable_cnt     = 0;
      resp_unready_cnt = 0;
      done_cnt         = 0;
      obs_reqs.delete();
    end else begin
      if (done_o) done_cnt++;
      dmi_resp_valid_i = 1'b0;
      dmi_resp_i       = '0;
      if (pending) begin
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = pend_resp;
        pending          = 1'b0;
        if (dmi_resp_ready_o !== 1'b1) resp_unready_cnt++;
      end
      if (dmi_req_valid_o) begin
        if (stall_cnt == 0) held_req = dmi_req_o;
        else if (dmi_req_o !== held_req) unstable_cnt++;
        if (stall_cnt < cfg_stall) begin
          dmi_req_ready_i = 1'b0;
          stall_cnt++;
        end else begin
          dmi_req_ready_i = 1'b1;
          stall_cnt       = 0;
          obs_reqs.push_back(dmi_req_o);
          req_cnt++;
          pending        = 1'b1;
          pend_resp      = '0;
          pend_resp.resp = (req_cnt == cfg_err_at) ? 2'd2 : 2'd0;
          if (dmi_req_o.op == dm::DTM_READ) begin
            if (poll_seen < cfg_busy) begin
              pend_resp.data[21] = 1'b1;
            end else begin
              pend_resp.data[22]    = cfg_sbbe;
              pend_resp.data[14:12] = cfg_sberr;
            end
            poll_seen++;
          end
        end
      end else begin
        dmi_req_ready_i = 1'b0;
        stall_cnt       = 0;
      end
    end
  end

  // Stream source: offers stream_words in order, counts accepted words
  int s_idx = 0, hs_cnt = 0;
  bit hs_adv = 1'b0;
  always @(negedge clk) begin
    if (!stream_en && !idle_offer) begin
      s_idx        = 0;
      hs_cnt       = 0;
      hs_adv       = 1'b0;
      data_valid_i = 1'b0;
      data_i       = '0;
      data_last_i  = 1'b0;
    end else begin
      if (hs_adv) begin
        s_idx++;
        hs_adv = 1'b0;
      end
      if (idle_offer) begin
        data_valid_i = 1'b1;
        data_i       = 32'hDEAD_BEEF;
        data_last_i  = 1'b1;
      end else if (s_idx < stream_words.size()) begin
        data_valid_i = cfg_gappy ? ($urandom_range(2) != 0) : 1'b1;
        data_i       = stream_words[s_idx];
        data_last_i  = (s_idx == stream_words.size() - 1);
      end else begin
        data_valid_i = 1'b0;
      end
      if (data_valid_i && data_ready_o) begin
        hs_cnt++;
        hs_adv = 1'b1;
      end
    end
  end

  // Reference model: the DMI transaction list a load must produce
  dm::dmi_req_t exp_reqs[$];
  int m_code, m_words, m_hs;

  function automatic dm::dmi_req_t mk(input logic [6:0] a, input dm::dtm_op_e op,
                                      input logic [31:0] d);
    dm::dmi_req_t r;
    r.addr = a;
    r.op   = op;
    r.data = d;
    return r;
  endfunction

  task automatic model(input logic [31:0] base, input int n, input int err_at,
                       input int busy, input logic [2:0] sberr, input bit sbbe);
    exp_reqs.delete();
    m_code  = 0;
    m_words = 0;
    m_hs    = 0;
    exp_reqs.push_back(mk(7'h38, dm::DTM_WRITE, 32'h0045_7000));
    if (exp_reqs.size() == err_at) begin m_code = 1; return; end
    exp_reqs.push_back(mk(7'h39, dm::DTM_WRITE, base));
    if (exp_reqs.size() == err_at) begin m_code = 1; return; end
    for (int i = 0; i < n; i++) begin
      m_hs++;
      exp_reqs.push_back(mk(7'h3C, dm::DTM_WRITE, stream_words[i]));
      if (exp_reqs.size() == err_at) begin m_code = 1; return; end
      m_words++;
    end
    for (int p = 0; p < MAX_POLL; p++) begin
      exp_reqs.push_back(mk(7'h38, dm::DTM_READ, 32'h0));
      if (exp_reqs.size() == err_at) begin m_code = 1; return; end
      if (p >= busy) begin
        m_code = sbbe ? 3 : ((sberr != 3'd0) ? 2 : 0);
        return;
      end
    end
    m_code = 4;
  endtask

  // Drive one complete load and wait (bounded) for done
  task automatic run_load(input logic [31:0] base, input int stall, input int err_at,
                          input int busy, input logic [2:0] sberr, input bit sbbe,
                          input bit gappy, input bit restart);
    cfg_stall  = stall;
    cfg_err_at = err_at;
    cfg_busy   = busy;
    cfg_sberr  = sberr;
    cfg_sbbe   = sbbe;
    cfg_gappy  = gappy;
    slave_en   = 1'b1;
    stream_en  = 1'b1;
    @(negedge clk);
    start_i     = 1'b1;
    base_addr_i = base;
    @(negedge clk);
    start_i     = 1'b0;
    base_addr_i = $urandom;
    check("start_to_req_valid", 64'(dmi_req_valid_o), 64'd1);
    if (restart) begin
      repeat (3) @(negedge clk);
      start_i     = 1'b1;
      base_addr_i = ~base;
      @(negedge clk);
      start_i = 1'b0;
    end
    for (int c = 0; c < 4000 && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_load(input string tag, input int nreq, input int code,
                            input int words, input int hs);
    check({tag, "_nreq"}, 64'(obs_reqs.size()), 64'(nreq));
    for (int i = 0; i < obs_reqs.size() && i < exp_reqs.size(); i++)
      check($sformatf("%s_req%0d", tag, i), 64'(obs_reqs[i]), 64'(exp_reqs[i]));
    check({tag, "_code"},     64'(err_code_o), 64'(code));
    check({tag, "_error"},    64'(error_o), 64'(code != 0));
    check({tag, "_words"},    64'(words_o), 64'(words));
    check({tag, "_hs"},       64'(hs_cnt), 64'(hs));
    check({tag, "_done"},     64'(done_cnt), 64'd1);
    check({tag, "_busy"},     64'(busy_o), 64'd0);
    check({tag, "_stable"},   64'(unstable_cnt), 64'd0);
    check({tag, "_rsprdy"},   64'(resp_unready_cnt), 64'd0);
    slave_en  = 1'b0;
    stream_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      64'(busy_o), 64'd0);
    check({tag, "_done"},      64'(done_o), 64'd0);
    check({tag, "_error"},     64'(error_o), 64'd0);
    check({tag, "_code"},      64'(err_code_o), 64'd0);
    check({tag, "_words"},     64'(words_o), 64'd0);
    check({tag, "_req_valid"}, 64'(dmi_req_valid_o), 64'd0);
    check({tag, "_req"},       64'(dmi_req_o), 64'd0);
    check({tag, "_data_rdy"},  64'(data_ready_o), 64'd0);
    check({tag, "_resp_rdy"},  64'(dmi_resp_ready_o), 64'd0);
  endtask

  typedef struct {
    logic [31:0] base;
    int          n, stall, err_at, busy;
    logic [2:0]  sberr;
    bit          sbbe, gappy, restart;
    int          exp_nreq, exp_code, exp_words, exp_hs;
  } scen_t;

  scen_t tbl[10];

  initial begin
    //                base           n stall err busy sberr sbbe gap rst  nreq code words hs
    tbl[0] = '{32'h1C00_0000, 4, 0, 0, 0,    3'd0, 1'b0, 1'b0, 1'b0, 7,  0, 4, 4};
    tbl[1] = '{32'h1C00_0000, 4, 5, 0, 0,    3'd0, 1'b0, 1'b0, 1'b1, 7,  0, 4, 4};
    tbl[2] = '{32'h1C00_0100, 4, 0, 0, 3,    3'd0, 1'b0, 1'b0, 1'b0, 10, 0, 4, 4};
    tbl[3] = '{32'h1C00_0200, 4, 1, 0, 1000, 3'd0, 1'b0, 1'b0, 1'b0, 14, 4, 4, 4};
    tbl[4] = '{32'h1C00_0300, 4, 0, 4, 0,    3'd0, 1'b0, 1'b0, 1'b0, 4,  1, 1, 2};
    tbl[5] = '{32'h1C00_0400, 4, 0, 0, 1,    3'd3, 1'b1, 1'b0, 1'b0, 8,  3, 4, 4};
    tbl[6] = '{32'h1C00_0500, 2, 2, 0, 0,    3'd5, 1'b0, 1'b0, 1'b0, 5,  2, 2, 2};
    tbl[7] = '{32'h1C00_0600, 3, 0, 1, 0,    3'd0, 1'b0, 1'b0, 1'b0, 1,  1, 0, 0};
    tbl[8] = '{32'h1C00_0700, 1, 0, 0, 0,    3'd0, 1'b0, 1'b1, 1'b0, 4,  0, 1, 1};
    tbl[9] = '{32'h1C00_0800, 3, 0, 7, 2,    3'd0, 1'b0, 1'b0, 1'b0, 7,  1, 3, 3};

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk);

    // A stream word offered while idle is never accepted
    idle_offer = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_data_ready", 64'(data_ready_o), 64'd0);
    check("idle_no_accept", 64'(hs_cnt), 64'd0);
    idle_offer = 1'b0;
    repeat (2) @(negedge clk);

    // Directed scenarios
    for (int t = 0; t < 10; t++) begin
      stream_words.delete();
      for (int k = 0; k < tbl[t].n; k++) stream_words.push_back(32'h11 * (k + 1));
      model(tbl[t].base, tbl[t].n, tbl[t].err_at, tbl[t].busy, tbl[t].sberr, tbl[t].sbbe);
      run_load(tbl[t].base, tbl[t].stall, tbl[t].err_at, tbl[t].busy, tbl[t].sberr,
               tbl[t].sbbe, tbl[t].gappy, tbl[t].restart);
      check_load($sformatf("t%0d", t), tbl[t].exp_nreq, tbl[t].exp_code,
                 tbl[t].exp_words, tbl[t].exp_hs);
    end

    // Reset while a sbdata0 request is pending, then a clean load
    begin
      bit found = 1'b0;
      stream_words.delete();
      for (int k = 0; k < 3; k++) stream_words.push_back(32'hA0 + k);
      cfg_stall  = 3;
      cfg_err_at = 0;
      cfg_busy   = 0;
      cfg_sberr  = '0;
      cfg_sbbe   = 1'b0;
      cfg_gappy  = 1'b0;
      slave_en   = 1'b1;
      stream_en  = 1'b1;
      @(negedge clk);
      start_i     = 1'b1;
      base_addr_i = 32'h1C00_1000;
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
        @(negedge clk);
        if (dmi_req_valid_o && dmi_req_o.addr == 7'h3C) found = 1'b1;
      end
      check("rst_reached_data_req", 64'(found), 64'd1);
      rst_i = 1'b1;
      @(negedge clk);
      check_all_zero("midrst");
      rst_i     = 1'b0;
      slave_en  = 1'b0;
      stream_en = 1'b0;
      repeat (2) @(negedge clk);
      model(32'h1C00_2000, 3, 0, 0, 3'd0, 1'b0);
      run_load(32'h1C00_2000, 0, 0, 0, 3'd0, 1'b0, 1'b0, 1'b0);
      check_load("after_rst", m_hs + 3, m_code, m_words, m_hs);
    end

    // Randomised loads against the reference model
    for (int r = 0; r < 20; r++) begin
      int n, stall, err_at, busy;
      logic [31:0] base;
      logic [2:0] sberr;
      bit sbbe;
      n      = $urandom_range(1, 6);
      stall  = $urandom_range(0, 3);
      busy   = $urandom_range(0, 10);
      base   = $urandom;
      sberr  = ($urandom_range(3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      sbbe   = ($urandom_range(4) == 0);
      err_at = ($urandom_range(3) == 0) ? $urandom_range(1, n + busy + 3) : 0;
      stream_words.delete();
      for (int k = 0; k < n; k++) stream_words.push_back($urandom);
      model(base, n, err_at, busy, sberr, sbbe);
      run_load(base, stall, err_at, busy, sberr, sbbe, 1'b1, 1'b0);
      check_load($sformatf("rnd%0d", r), exp_reqs.size(), m_code, m_words, m_hs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/safety_island_dmi_loader.md
# safety_island_dmi_loader

Hardware preload engine that drives the debug module's DMI port to copy a stream of 32-bit words into Safety Island memory through System Bus Access (SBA). It sits directly upstream of the debug module's DMI slave, in place of the JTAG TAP/DMI front end. It gives a host-side or flash-side streamer the same load path that a JTAG binary load uses, without bit-banging JTAG. It reports completion and any bus or DMI error, so the boot controller can resume the hart.

## Interface
- `MaxPoll`, default 1024: sbcs busy-poll reads before timeout.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: single-cycle pulse starting a load; ignored unless `busy_o`=0.
- `base_addr_i` in 32: target byte address, sampled on `start_i`.
- `data_valid_i` in 1: stream word valid.
- `data_ready_o` out 1: stream word accepted.
- `data_i` in 32: word to store.
- `data_last_i` in 1: final word of the load.
- `dmi_req_valid_o` out 1: DMI request valid.
- `dmi_req_ready_i` in 1: DMI request ready.
- `dmi_req_o` out 41: `dm::dmi_req_t` {addr[6:0], op[1:0], data[31:0]}.
- `dmi_resp_valid_i` in 1: DMI response valid.
- `dmi_resp_ready_o` out 1: DMI response ready.
- `dmi_resp_i` in 34: `dm::dmi_resp_t` {data[31:0], resp[1:0]}.
- `busy_o` out 1: load in progress.
- `done_o` out 1: one-cycle pulse at the end of a load, successful or not.
- `error_o` out 1: sticky; error code nonzero; cleared by the next `start_i`.
- `err_code_o` out 3: 0 none, 1 DMI resp≠0, 2 sberror≠0, 3 sbbusyerror, 4 poll timeout.
- `words_o` out 32: words written in the current or last load.

## Operation
- FSM states: IDLE → CFG_REQ → CFG_RSP → ADDR_REQ → ADDR_RSP → DATA_WAIT → DATA_REQ → DATA_RSP → (DATA_WAIT | POLL_REQ) → POLL_RSP → (POLL_REQ | FIN) → IDLE.
- CFG: write sbcs (0x38), op=2, data 0x0045_7000:
  - sbaccess=2 (32-bit) and sbautoincrement=1;
  - the write also clears sbbusyerror and sberror.
- ADDR: write sbaddress0 (0x39) = latched base address.
- DATA_WAIT: `data_ready_o`=1. On handshake, latch word and last flag, then go to DATA_REQ.
- DATA_REQ/RSP: write sbdata0 (0x3C) = word. On response, increment `words_o`.
  - Last flag set: go to POLL_REQ.
  - Otherwise: return to DATA_WAIT.
- POLL: read sbcs (op=1) and inspect the response.
  - Any error (DMI resp, sberror, sbbusyerror, timeout): FIN with the matching code.
  - sbbusy (bit 21)=1: reissue the poll, up to `MaxPoll` reads, then timeout.
  - Otherwise: FIN with code 0.
- Error priority within one response: DMI resp > sbbusyerror (bit 22) > sberror (bits 14:12).
- Any DMI resp≠0 in any RSP state: go straight to FIN, error code 1, and drop any remaining stream words (the upstream is reset by the owner).
- FIN: pulse `done_o`, then return to IDLE.
- `start_i` while busy is ignored. A stream word presented in IDLE is not accepted.

## Timing
- Reset values: all outputs 0; `dmi_req_o` = 0; FSM = IDLE; counters 0.
- `dmi_req_valid_o` and `dmi_req_o` are registered. Once valid rises, both hold stable until `dmi_req_ready_i`.
- `dmi_resp_ready_o`=1 combinationally in RSP states only.
- `data_ready_o` is combinational from state only, with no dependence on `data_valid_i`.
- Start to first DMI request valid: 1 cycle.
- Minimum per-word cost, with zero-latency DMI: 3 cycles (DATA_WAIT, DATA_REQ, DATA_RSP).
- `done_o` is asserted the cycle after the final response. `busy_o` falls on the same edge.
- `words_o` wraps at 2^32 with no error.
- `rst_i` mid-load aborts to IDLE at the next edge.
  - Any outstanding DMI response is dropped.
  - The debug module's DMI response queue must be flushed by the shared reset.

## Structure
- DMI register address constants (sbcs, sbaddress0, sbdata0), the sbcs config word and the error-code enum go in `safety_island_pkg`.
- `dm::dmi_req_t`, `dm::dmi_resp_t` and the DMI op encoding are reused from `dm_pkg`.
- Single flat FSM module; no sub-module.

## Test plan
- Start with base 0x1C00_0000, 4 words 0x11,0x22,0x33,0x44 (last on 4th), ideal DMI model:
  - DMI writes in order: 0x38←0x0045_7000, 0x39←0x1C00_0000, 0x3C←0x11…0x44;
  - then one sbcs read;
  - `done_o` once, `error_o`=0, `words_o`=4.
- DMI ready held low for 5 cycles on each request: requests stay stable and no duplicates are issued; result identical.
- sbcs poll returns busy 3 times, then idle: 4 reads issued, code 0.
- Poll permanently busy with `MaxPoll`=8: 8 reads, then `error_o`=1, code 4.
- DMI resp=2 on the 2nd sbdata0 write: FIN immediately, code 1, `words_o`=1, no further stream handshakes.
- `rst_i` asserted during DATA_REQ: next cycle all outputs 0, FSM IDLE; a new start completes normally.
